fifo_slave_port: RTL and testbench
==================================

// Module: fifo_slave_port
// PURPOSE
//  Slave-side controller for the dual SN74HCT40105 FIFO pair behind the LVC74245 level shifters.
//  Replaces software GPIO bit-banging with a sequential engine:
//   - drains the host->slave FIFO into an rx byte stream;
//   - fills the slave->host FIFO from a tx byte stream.
//  Generates SI, SOB and WNR with programmable pulse and setup timing.
//  Also drives the shared 8-bit sd bus.
// PARAMETERS
//  PULSE_CYCLES  4  width of SI-high and SOB-low pulses, in clk cycles (>=1)
//  SETUP_CYCLES  2  bus turnaround/data setup before strobe and data hold after SI (>=1)
// PORTS
//  clk       in   1  system clock; all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  fifo_dir  in   1  slave->host FIFO DIR (1 = space available); asynchronous
//  fifo_dor  in   1  host->slave FIFO DOR (1 = byte at Q); asynchronous
//  fifo_si   out  1  shift-in strobe to slave->host FIFO, active high
//  fifo_sob  out  1  shift-out strobe to host->slave FIFO, active low
//  fifo_wnr  out  1  1 = write: FIFO Q tri-stated (oeb), shifter drives toward FIFO; 0 = read
//  sd_out    out  8  byte driven onto sd bus when sd_oe=1
//  sd_oe     out  1  sd bus output enable
//  sd_in     in   8  sd bus sampled value (FIFO Q in read mode)
//  tx_data   in   8  byte to send to host
//  tx_valid  in   1  tx_data valid
//  tx_ready  out  1  transfer accepted when tx_valid & tx_ready
//  rx_data   out  8  byte received from host
//  rx_valid  out  1  rx_data valid; held until rx_ready
//  rx_ready  in   1  consumer accepts rx_data when rx_valid & rx_ready
// BEHAVIOUR
//  - Reset values: fifo_si=0, fifo_sob=1, fifo_wnr=0, sd_oe=0, sd_out=0, rx_data=0, rx_valid=0, state=IDLE, last_op=WRITE.
//  - fifo_dir and fifo_dor pass through 2-flop synchronisers (dir_s, dor_s); reset to 0.
//  - tx_ready = (state==IDLE) & dir_s & grant_wr. It is a combinational decode of registered state.
//  - Eligibility:
//     wr_elig = tx_valid & dir_s
//     rd_elig = dor_s & !rx_valid
//  - Arbitration: if both are eligible, grant the opposite of last_op. After reset, read wins.
//  - States:
//     IDLE: on grant_wr, latch tx_data into sd_out; set fifo_wnr=1, sd_oe=1; go to WR_SETUP.
//           Else on grant_rd, go to RD_SETUP (fifo_wnr already 0).
//     WR_SETUP: SETUP_CYCLES cycles, then fifo_si=1 and go to WR_PULSE.
//     WR_PULSE: PULSE_CYCLES cycles with si high. Then si=0; go to WR_HOLD.
//     WR_HOLD: SETUP_CYCLES cycles. Then sd_oe=0, fifo_wnr=0, last_op=WRITE; go to RECOVER.
//     RD_SETUP: SETUP_CYCLES cycles. Then capture sd_in into rx_data, rx_valid=1, fifo_sob=0; go to RD_PULSE.
//     RD_PULSE: PULSE_CYCLES cycles with sob low. Then sob=1, last_op=READ; go to RECOVER.
//     RECOVER: 3 cycles, which flushes the synchronisers so stale DIR/DOR is not reused. Then go to IDLE.
//  - rx_valid clears on the cycle rx_valid & rx_ready is sampled. It is never set and cleared in the same cycle.
//    No second read starts while rx_valid=1.
//  - Latency, IDLE to data strobe:
//     write: SETUP_CYCLES + 1 cycles to fifo_si rise
//     read:  SETUP_CYCLES + 1 cycles to rx_valid
//  - Full cycle: write = 2*SETUP_CYCLES + PULSE_CYCLES + 4; read = SETUP_CYCLES + PULSE_CYCLES + 4.
//  - sd_oe and fifo_wnr change only together. sd_oe is never 1 while fifo_wnr=0, so there is no bus contention.
//  - FIFO full (dir_s=0): tx_ready held 0; tx byte waits upstream.
//  - FIFO empty (dor_s=0): no read is started.
//  - tx_valid dropping after acceptance has no effect; the byte is already latched.
//  - Reset mid-operation: next edge forces all reset values. si drops, sob rises, bus released. The in-flight byte is lost.
//  - Timing counter width is $clog2(max(PULSE_CYCLES,SETUP_CYCLES,3))+1. The counter reloads on each state entry.
// CONFIGURATION
//  FIFO_SLAVE_COUNT_EN defined:
//   - Adds outputs tx_count[15:0] and rx_count[15:0].
//   - tx_count increments on every fifo_si rising edge; rx_count on every rx capture.
//   - Both wrap 0xFFFF->0x0000 and are 0 after reset.
//  FIFO_SLAVE_COUNT_EN undefined:
//   - Ports and counters are absent. All other behaviour is identical.
// TESTING
//  - Reset: hold reset 2 cycles mid WR_PULSE.
//     -> next cycle si=0, sob=1, wnr=0, sd_oe=0, rx_valid=0, tx_ready=0.
//  - Single write: dir=1, tx_data=0xA5 pulsed with valid (defaults).
//     -> wnr=sd_oe=1, sd_out=0xA5; si high exactly 4 cycles, 3 cycles after acceptance; bus released 2 cycles after si falls.
//  - Single read: dor=1, sd_in=0x3C, rx_ready=0.
//     -> rx_data=0x3C, rx_valid=1, sob low 4 cycles; with dor held 1, no further sob until rx_ready pulses.
//  - Contention: dir=1, dor=1, tx_valid=1 continuously, rx_ready=1.
//     -> after reset, operations alternate read, write, read, write. wnr never 1 during sob low.
//  - Full/empty: dir=0 with tx_valid=1 for 50 cycles -> tx_ready stays 0, si stays 0.
//     Raise dir -> write completes. dor=0 -> sob stays 1.
//  - FIFO_SLAVE_COUNT_EN: preload via 65537 writes -> tx_count wraps to 0x0001. rx_count unaffected.

Source files
------------

// File: rtl/fifo_slave_port_if.sv
// Handshake and bus bundle between the slave-side FIFO engine and its surroundings.
// slave: the controller's view. master: the view of the FIFO pins and byte streams that drive it.
interface fifo_slave_port_if;
  logic       fifo_dir;
  logic       fifo_dor;
  logic       fifo_si;
  logic       fifo_sob;
  logic       fifo_wnr;
  logic [7:0] sd_out;
  logic       sd_oe;
  logic [7:0] sd_in;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport slave (
    input  fifo_dir, fifo_dor, sd_in, tx_data, tx_valid, rx_ready,
    output fifo_si, fifo_sob, fifo_wnr, sd_out, sd_oe, tx_ready, rx_data, rx_valid
  );

  modport master (
    output fifo_dir, fifo_dor, sd_in, tx_data, tx_valid, rx_ready,
    input  fifo_si, fifo_sob, fifo_wnr, sd_out, sd_oe, tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/fifo_slave_port.sv
// Sequential engine that drains the host->slave SN74HCT40105 into rx and fills the slave->host one from tx.
// Optional feature macro: FIFO_SLAVE_COUNT_EN adds the tx_count/rx_count transfer counters.
module fifo_slave_port #(
  parameter int PULSE_CYCLES = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  fifo_slave_port_if.slave    bus
`ifdef FIFO_SLAVE_COUNT_EN
  ,
  output logic [15:0]         tx_count,
  output logic [15:0]         rx_count
`endif
);

  localparam int MAX_PS = (PULSE_CYCLES > SETUP_CYCLES) ? PULSE_CYCLES : SETUP_CYCLES;
  localparam int MAX_C  = (MAX_PS > 3) ? MAX_PS : 3;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(2);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_RD_SETUP, S_RD_PULSE, S_RECOVER
  } state_t;

  typedef enum logic {OP_WRITE, OP_READ} op_t;

  logic             r_dir_s1, r_dir_s, r_dor_s1, r_dor_s;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_si, w_si_nxt;
  logic             r_sob, w_sob_nxt;
  logic             r_wnr, w_wnr_nxt;
  logic             r_oe, w_oe_nxt;
  logic [7:0]       r_sd_out, w_sd_out_nxt;
  logic [7:0]       r_rx_data, w_rx_data_nxt;
  logic             r_rx_valid, w_rx_valid_nxt;
  op_t              r_last_op, w_last_op_nxt;
  logic             w_wr_elig, w_rd_elig, w_grant_wr, w_grant_rd;
  logic             w_si_rise, w_rx_cap;

  // DIR/DOR come straight off the FIFO pins, unrelated to clk
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dir_s1 <= 1'b0;
      r_dir_s  <= 1'b0;
      r_dor_s1 <= 1'b0;
      r_dor_s  <= 1'b0;
    end else begin
      r_dir_s1 <= bus.fifo_dir;
      r_dir_s  <= r_dir_s1;
      r_dor_s1 <= bus.fifo_dor;
      r_dor_s  <= r_dor_s1;
    end
  end

  assign w_wr_elig  = bus.tx_valid & r_dir_s;
  assign w_rd_elig  = r_dor_s & ~r_rx_valid;
  assign w_grant_wr = w_wr_elig & (~w_rd_elig | (r_last_op == OP_READ));
  assign w_grant_rd = w_rd_elig & (~w_wr_elig | (r_last_op == OP_WRITE));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_si       <= 1'b0;
      r_sob      <= 1'b1;
      r_wnr      <= 1'b0;
      r_oe       <= 1'b0;
      r_sd_out   <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_last_op  <= OP_WRITE;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_si       <= w_si_nxt;
      r_sob      <= w_sob_nxt;
      r_wnr      <= w_wnr_nxt;
      r_oe       <= w_oe_nxt;
      r_sd_out   <= w_sd_out_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_last_op  <= w_last_op_nxt;
    end
  end

  // Every state exits when its down-counter reaches zero; each exit reloads it for the next state
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = (r_cnt != '0) ? r_cnt - CNT_W'(1) : r_cnt;
    w_si_nxt       = r_si;
    w_sob_nxt      = r_sob;
    w_wnr_nxt      = r_wnr;
    w_oe_nxt       = r_oe;
    w_sd_out_nxt   = r_sd_out;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = r_rx_valid & ~bus.rx_ready;
    w_last_op_nxt  = r_last_op;
    case (r_state)
      S_IDLE: begin
        if (w_grant_wr) begin
          w_sd_out_nxt = bus.tx_data;
          w_wnr_nxt    = 1'b1;
          w_oe_nxt     = 1'b1;
          w_state_nxt  = S_WR_SETUP;
          w_cnt_nxt    = SETUP_LD;
        end else if (w_grant_rd) begin
          w_state_nxt  = S_RD_SETUP;
          w_cnt_nxt    = SETUP_LD;
        end
      end
      S_WR_SETUP: if (r_cnt == '0) begin
        w_si_nxt    = 1'b1;
        w_state_nxt = S_WR_PULSE;
        w_cnt_nxt   = PULSE_LD;
      end
      S_WR_PULSE: if (r_cnt == '0) begin
        w_si_nxt    = 1'b0;
        w_state_nxt = S_WR_HOLD;
        w_cnt_nxt   = SETUP_LD;
      end
      S_WR_HOLD: if (r_cnt == '0) begin
        w_oe_nxt      = 1'b0;
        w_wnr_nxt     = 1'b0;
        w_last_op_nxt = OP_WRITE;
        w_state_nxt   = S_RECOVER;
        w_cnt_nxt     = RECOVER_LD;
      end
      S_RD_SETUP: if (r_cnt == '0) begin
        w_rx_data_nxt  = bus.sd_in;
        w_rx_valid_nxt = 1'b1;
        w_sob_nxt      = 1'b0;
        w_state_nxt    = S_RD_PULSE;
        w_cnt_nxt      = PULSE_LD;
      end
      S_RD_PULSE: if (r_cnt == '0) begin
        w_sob_nxt     = 1'b1;
        w_last_op_nxt = OP_READ;
        w_state_nxt   = S_RECOVER;
        w_cnt_nxt     = RECOVER_LD;
      end
      S_RECOVER: if (r_cnt == '0) begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_si_rise = (r_state == S_WR_SETUP) && (r_cnt == '0);
  assign w_rx_cap  = (r_state == S_RD_SETUP) && (r_cnt == '0);

`ifdef FIFO_SLAVE_COUNT_EN
  logic [15:0] r_tx_count, r_rx_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_count <= 16'h0000;
      r_rx_count <= 16'h0000;
    end else begin
      if (w_si_rise) r_tx_count <= r_tx_count + 16'h0001;
      if (w_rx_cap)  r_rx_count <= r_rx_count + 16'h0001;
    end
  end

  assign tx_count = r_tx_count;
  assign rx_count = r_rx_count;
`else
  logic w_unused_strobes;
  assign w_unused_strobes = w_si_rise ^ w_rx_cap;
`endif

  assign bus.tx_ready = (r_state == S_IDLE) & r_dir_s & w_grant_wr;
  assign bus.fifo_si  = r_si;
  assign bus.fifo_sob = r_sob;
  assign bus.fifo_wnr = r_wnr;
  assign bus.sd_oe    = r_oe;
  assign bus.sd_out   = r_sd_out;
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;

endmodule

// File: tb/tb_fifo_slave_port.sv
// Directed bench for fifo_slave_port: reset, single write/read, contention, full/empty, reset mid-pulse.
module tb_fifo_slave_port;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fifo_slave_port_if bus ();

`ifdef FIFO_SLAVE_COUNT_EN
  logic [15:0] tx_count, rx_count;
  fifo_slave_port dut (.clk(clk), .reset(reset), .bus(bus), .tx_count(tx_count), .rx_count(rx_count));
`else
  fifo_slave_port dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int found, si_hi, si_rise_at, oe_fall_at, lows, extra, nops, viol, rdy_cnt, si_cnt;
  int ops [8];
  logic prev_sob, prev_si;

  initial begin
    reset = 1'b1;
    bus.fifo_dir = 1'b0; bus.fifo_dor = 1'b0; bus.sd_in = 8'h00;
    bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;
    tick(2);
    reset = 1'b0;
    check("rst_si", bus.fifo_si, 1'b0);
    check("rst_sob", bus.fifo_sob, 1'b1);
    check("rst_wnr", bus.fifo_wnr, 1'b0);
    check("rst_oe", bus.sd_oe, 1'b0);
    check("rst_sd_out", bus.sd_out, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 1'b0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_tx_ready", bus.tx_ready, 1'b0);

    // single write
    bus.fifo_dir = 1'b1; bus.tx_data = 8'hA5; bus.tx_valid = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.tx_ready === 1'b1) found = 1;
    end
    check("wr_accept_seen", found, 1);
    tick(1);
    bus.tx_valid = 1'b0;
    check("wr_wnr", bus.fifo_wnr, 1'b1);
    check("wr_oe", bus.sd_oe, 1'b1);
    check("wr_sd_out", bus.sd_out, 8'hA5);
    check("wr_si_not_yet", bus.fifo_si, 1'b0);
    si_hi = 0; si_rise_at = -1; oe_fall_at = -1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      if (bus.fifo_si === 1'b1) begin
        si_hi++;
        if (si_rise_at < 0) si_rise_at = i;
      end
      if (bus.sd_oe === 1'b0 && oe_fall_at < 0) oe_fall_at = i;
    end
    check("wr_si_width", si_hi, 4);
    check("wr_si_rise_offset", si_rise_at, 2);
    check("wr_oe_fall_offset", oe_fall_at, 8);
    check("wr_wnr_released", bus.fifo_wnr, 1'b0);
    bus.fifo_dir = 1'b0;
    tick(3);

    // single read, consumer stalled
    bus.fifo_dor = 1'b1; bus.sd_in = 8'h3C;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.rx_valid === 1'b1) found = 1;
    end
    check("rd_valid_seen", found, 1);
    check("rd_data", bus.rx_data, 8'h3C);
    lows = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.fifo_sob === 1'b0) lows++;
      tick(1);
    end
    check("rd_sob_width", lows, 4);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (bus.fifo_sob === 1'b0) extra++;
    end
    check("rd_stall_no_sob", extra, 0);
    check("rd_valid_held", bus.rx_valid, 1'b1);
    bus.sd_in = 8'h5A; bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("rd_valid_cleared", bus.rx_valid, 1'b0);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.rx_valid === 1'b1) found = 1;
    end
    check("rd2_valid_seen", found, 1);
    check("rd2_data", bus.rx_data, 8'h5A);
    bus.fifo_dor = 1'b0;
    tick(12);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bus.fifo_sob === 1'b0) extra++;
    end
    check("empty_no_sob", extra, 0);

    // contention: both sides always ready
    bus.fifo_dir = 1'b1; bus.fifo_dor = 1'b1; bus.tx_valid = 1'b1;
    bus.tx_data = 8'h11; bus.rx_ready = 1'b1; bus.sd_in = 8'h22;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    prev_sob = bus.fifo_sob; prev_si = bus.fifo_si;
    nops = 0; viol = 0;
    for (int i = 0; i < 8; i++) ops[i] = -1;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (prev_sob === 1'b1 && bus.fifo_sob === 1'b0 && nops < 8) begin ops[nops] = 0; nops++; end
      if (prev_si === 1'b0 && bus.fifo_si === 1'b1 && nops < 8) begin ops[nops] = 1; nops++; end
      if (bus.fifo_sob === 1'b0 && bus.fifo_wnr === 1'b1) viol++;
      if (bus.sd_oe === 1'b1 && bus.fifo_wnr === 1'b0) viol++;
      prev_sob = bus.fifo_sob; prev_si = bus.fifo_si;
    end
    check("cont_op0_read", ops[0], 0);
    check("cont_op1_write", ops[1], 1);
    check("cont_op2_read", ops[2], 0);
    check("cont_op3_write", ops[3], 1);
    check("cont_bus_safety", viol, 0);

    // full and empty, then release dir
    bus.fifo_dir = 1'b0; bus.fifo_dor = 1'b0; bus.tx_valid = 1'b1;
    bus.tx_data = 8'h77; bus.rx_ready = 1'b0;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    rdy_cnt = 0; si_cnt = 0; lows = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (bus.tx_ready === 1'b1) rdy_cnt++;
      if (bus.fifo_si === 1'b1) si_cnt++;
      if (bus.fifo_sob === 1'b0) lows++;
    end
    check("full_tx_ready", rdy_cnt, 0);
    check("full_si", si_cnt, 0);
    check("empty_sob", lows, 0);
    bus.fifo_dir = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.tx_ready === 1'b1) found = 1;
    end
    check("full_release_accept", found, 1);
    tick(1);
    bus.tx_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      tick(1);
      if (bus.fifo_si === 1'b1) found = 1;
    end
    check("full_release_si", found, 1);
    check("full_release_sd_out", bus.sd_out, 8'h77);

    // reset in the middle of the si pulse
    tick(1);
    check("mid_pulse_si_high", bus.fifo_si, 1'b1);
    reset = 1'b1;
    tick(1);
    check("midrst_si", bus.fifo_si, 1'b0);
    check("midrst_sob", bus.fifo_sob, 1'b1);
    check("midrst_wnr", bus.fifo_wnr, 1'b0);
    check("midrst_oe", bus.sd_oe, 1'b0);
    check("midrst_rx_valid", bus.rx_valid, 1'b0);
    check("midrst_tx_ready", bus.tx_ready, 1'b0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check("postrst_si", bus.fifo_si, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
